chi5pc_pcrd_retry_tracker: RTL and testbench
============================================

// Module: chi5pc_pcrd_retry_tracker
// PURPOSE
//  Scoreboard stage feeding the CHI5 protocol checker's retry/credit assertions. Sits on the RN-side link monitor.
//  Pairs RetryAck, PCrdGrant and retried-request reissue per (RN id, PCrdType).
//  Flags credit-protocol violations as registered one-cycle error pulses.
// PARAMETERS
//  DEPTH          16    tracker entries (power of 2, >=2)
//  ID_WIDTH       7     CHI NodeID width
//  TXNID_WIDTH    8     TxnID width
//  PCRD_WIDTH     4     PCrdType width
//  TIMEOUT        1024  max cycles an entry may stay live; 0 disables timeout
// PORTS
//  SCLK             in   1            clock, all logic on rising edge
//  SRESET           in   1            synchronous reset, active-high
//  retry_vld        in   1            RetryAck observed this cycle
//  retry_rn_id      in   ID_WIDTH     TgtID of RetryAck (requesting RN)
//  retry_txnid      in   TXNID_WIDTH  TxnID of RetryAck
//  retry_pcrdtype   in   PCRD_WIDTH   PCrdType carried by RetryAck
//  grant_vld        in   1            PCrdGrant observed this cycle
//  grant_rn_id      in   ID_WIDTH     TgtID of PCrdGrant
//  grant_pcrdtype   in   PCRD_WIDTH   PCrdType of PCrdGrant
//  reissue_vld      in   1            REQ with AllowRetry=0 observed
//  reissue_rn_id    in   ID_WIDTH     SrcID of reissued REQ
//  reissue_pcrdtype in   PCRD_WIDTH   PCrdType of reissued REQ
//  eos              in   1            end-of-simulation strobe
//  live_cnt         out  clogb2(DEPTH)+1  number of non-FREE entries
//  err_overflow     out  1            allocation needed, table full
//  err_dup_retry    out  1            RetryAck rn_id/txnid already RETRIED
//  err_no_credit    out  1            reissue with no CREDITED match
//  err_timeout      out  1            entry exceeded TIMEOUT
//  err_eos          out  1            live entries at eos
//  err_rn_id        out  ID_WIDTH     rn_id of highest-priority error
//  err_txnid        out  TXNID_WIDTH  txnid of that error (0 if n/a)
// BEHAVIOUR
//  Reset: all entries FREE, ages 0, live_cnt=0, every err_*=0, err_rn_id=0, err_txnid=0.
//  Entry fields: state, rn_id, txnid, pcrdtype, age, to_flag. States: FREE, RETRIED, GRANT_ONLY, CREDITED.
//  Matching uses pre-edge state. Lowest index wins on ties and allocation.
//  retry_vld: GRANT_ONLY match(rn,type) -> CREDITED, store txnid. Else if same-cycle grant matches rn,type,
//   allocate one entry directly CREDITED; grant consumed. Else allocate RETRIED.
//   Existing RETRIED entry with same rn,txnid -> err_dup_retry; the new one is still tracked.
//  grant_vld (not consumed above): RETRIED match(rn,type) -> CREDITED. Else allocate GRANT_ONLY (early grant legal).
//  reissue_vld: CREDITED match(rn,type) -> FREE. Else err_no_credit.
//   A grant or retry in the same cycle does not satisfy a reissue.
//  Up to 2 allocations per cycle. Retry allocates before grant. Failing allocation -> err_overflow, event dropped.
//  A freed entry is reusable the next cycle, not the same cycle.
//  Age: +1 per cycle while non-FREE, saturating; cleared on allocation.
//   age==TIMEOUT-1 with to_flag=0 -> err_timeout, set to_flag (once per entry).
//  eos with live_cnt!=0 -> err_eos.
//  Errors are registered, 1-cycle latency, 1-cycle pulse.
//   err_rn_id/txnid priority: overflow > dup_retry > no_credit > timeout > eos. Hold last value otherwise.
//  live_cnt reflects post-edge state. Max DEPTH, never wraps.
//  SRESET mid-operation: all entries FREE next cycle; events on the reset cycle are ignored.
// TESTING
//  1 retry(rn=5,tx=3,t=1); grant(5,1) @+4; reissue(5,1) @+8 -> live_cnt 1,1,0; no errors.
//  2 grant(2,0) first, retry(2,tx=9,t=0) @+3, reissue @+5 -> GRANT_ONLY->CREDITED->FREE; no errors.
//  3 reissue(7,2) with empty table -> err_no_credit=1 next cycle, err_rn_id=7.
//  4 retry+grant same cycle (rn=1,t=3), reissue next cycle -> one entry CREDITED, then FREE; no errors.
//  5 DEPTH+1 retries to distinct txnids -> err_overflow on the last one; live_cnt=DEPTH.
//  6 TIMEOUT=8, retry with no grant -> err_timeout 8 cycles after alloc, once; eos -> err_eos; SRESET -> live_cnt 0.

Source files
------------

// File: rtl/chi5pc_pcrd_retry_tracker.sv
// chi5pc_pcrd_retry_tracker
// Pairs RetryAck, PCrdGrant and retried-request reissue per (RN id, PCrdType)
// on the RN-side link and flags credit-protocol violations as registered
// one-cycle pulses. All matching is against the table state before the edge.
module chi5pc_pcrd_retry_tracker #(
    parameter int DEPTH       = 16,
    parameter int ID_WIDTH    = 7,
    parameter int TXNID_WIDTH = 8,
    parameter int PCRD_WIDTH  = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                      SCLK,
    input  logic                      SRESET,
    input  logic                      retry_vld,
    input  logic [ID_WIDTH-1:0]       retry_rn_id,
    input  logic [TXNID_WIDTH-1:0]    retry_txnid,
    input  logic [PCRD_WIDTH-1:0]     retry_pcrdtype,
    input  logic                      grant_vld,
    input  logic [ID_WIDTH-1:0]       grant_rn_id,
    input  logic [PCRD_WIDTH-1:0]     grant_pcrdtype,
    input  logic                      reissue_vld,
    input  logic [ID_WIDTH-1:0]       reissue_rn_id,
    input  logic [PCRD_WIDTH-1:0]     reissue_pcrdtype,
    input  logic                      eos,
    output logic [$clog2(DEPTH):0]    live_cnt,
    output logic                      err_overflow,
    output logic                      err_dup_retry,
    output logic                      err_no_credit,
    output logic                      err_timeout,
    output logic                      err_eos,
    output logic [ID_WIDTH-1:0]       err_rn_id,
    output logic [TXNID_WIDTH-1:0]    err_txnid
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int AGE_W = $clog2(TIMEOUT + 2);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] TO_LIM  = AGE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] FREE       = 2'd0;
    localparam logic [1:0] RETRIED    = 2'd1;
    localparam logic [1:0] GRANT_ONLY = 2'd2;
    localparam logic [1:0] CREDITED   = 2'd3;

    logic [1:0]             entState [DEPTH];
    logic [ID_WIDTH-1:0]    entRn    [DEPTH];
    logic [TXNID_WIDTH-1:0] entTxn   [DEPTH];
    logic [PCRD_WIDTH-1:0]  entPcrd  [DEPTH];
    logic [AGE_W-1:0]       entAge   [DEPTH];
    logic                   entTo    [DEPTH];

    logic             goHit, dupHit, rtHit, crHit, toHit, liveHit, free0Hit, free1Hit;
    logic [IDX_W-1:0] goIdx, rtIdx, crIdx, toIdx, liveIdx, free0Idx, free1Idx;
    logic             grantConsumed, retryAlloc, grantAlloc, retryOvf, grantOvf;
    logic             grantSlotHit;
    logic [IDX_W-1:0] grantSlot;
    logic [CNT_W-1:0] liveCount;

    // Lowest-index search over the pre-edge table for every kind of match.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        {goHit, dupHit, rtHit, crHit, toHit, liveHit, free0Hit, free1Hit} = '0;
        {goIdx, rtIdx, crIdx, toIdx, liveIdx, free0Idx, free1Idx} = '0;
        liveCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entState[i] != FREE) liveCount = liveCount + 1'b1;
            if (!goHit && entState[i] == GRANT_ONLY && entRn[i] == retry_rn_id &&
                entPcrd[i] == retry_pcrdtype) begin
                goHit = 1'b1; goIdx = IDX_W'(i);
            end
            if (entState[i] == RETRIED && entRn[i] == retry_rn_id && entTxn[i] == retry_txnid)
                dupHit = 1'b1;
            if (!rtHit && entState[i] == RETRIED && entRn[i] == grant_rn_id &&
                entPcrd[i] == grant_pcrdtype) begin
                rtHit = 1'b1; rtIdx = IDX_W'(i);
            end
            if (!crHit && entState[i] == CREDITED && entRn[i] == reissue_rn_id &&
                entPcrd[i] == reissue_pcrdtype) begin
                crHit = 1'b1; crIdx = IDX_W'(i);
            end
            if (TIMEOUT != 0 && !toHit && entState[i] != FREE && !entTo[i] &&
                entAge[i] >= TO_LIM) begin
                toHit = 1'b1; toIdx = IDX_W'(i);
            end
            if (!liveHit && entState[i] != FREE) begin
                liveHit = 1'b1; liveIdx = IDX_W'(i);
            end
            if (entState[i] == FREE) begin
                if (!free0Hit) begin
                    free0Hit = 1'b1; free0Idx = IDX_W'(i);
                end else if (!free1Hit) begin
                    free1Hit = 1'b1; free1Idx = IDX_W'(i);
                end
            end
        end
    end

    // Event resolution: which events allocate, which slot each takes, which overflow.
    always_comb begin
        grantConsumed = retry_vld && !goHit && grant_vld &&
                        grant_rn_id == retry_rn_id && grant_pcrdtype == retry_pcrdtype;
        retryAlloc    = retry_vld && !goHit;
        grantAlloc    = grant_vld && !grantConsumed && !rtHit;
        retryOvf      = retryAlloc && !free0Hit;
        grantSlotHit  = retryAlloc ? free1Hit : free0Hit;
        grantSlot     = retryAlloc ? free1Idx : free0Idx;
        grantOvf      = grantAlloc && !grantSlotHit;
    end

    assign live_cnt = liveCount;

    // Table update: ageing, state transitions and allocations.
    always_ff @(posedge SCLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (SRESET) begin
                // NOTE: the whole table is reset, not only state, so ages and flags start clean.
                entState[i] <= FREE;
                entRn[i]    <= '0;
                entTxn[i]   <= '0;
                entPcrd[i]  <= '0;
                entAge[i]   <= '0;
                entTo[i]    <= 1'b0;
            end else begin
                if (entState[i] != FREE && entAge[i] != AGE_MAX) entAge[i] <= entAge[i] + 1'b1;
                if (toHit && toIdx == IDX_W'(i)) entTo[i] <= 1'b1;
                if (retry_vld && goHit && goIdx == IDX_W'(i)) begin
                    entState[i] <= CREDITED;
                    entTxn[i]   <= retry_txnid;
                end
                if (grant_vld && !grantConsumed && rtHit && rtIdx == IDX_W'(i))
                    entState[i] <= CREDITED;
                if (reissue_vld && crHit && crIdx == IDX_W'(i))
                    entState[i] <= FREE;
                if (retryAlloc && free0Hit && free0Idx == IDX_W'(i)) begin
                    entState[i] <= grantConsumed ? CREDITED : RETRIED;
                    entRn[i]    <= retry_rn_id;
                    entTxn[i]   <= retry_txnid;
                    entPcrd[i]  <= retry_pcrdtype;
                    entAge[i]   <= '0;
                    entTo[i]    <= 1'b0;
                end
                if (grantAlloc && grantSlotHit && grantSlot == IDX_W'(i)) begin
                    entState[i] <= GRANT_ONLY;
                    entRn[i]    <= grant_rn_id;
                    entTxn[i]   <= '0;
                    entPcrd[i]  <= grant_pcrdtype;
                    entAge[i]   <= '0;
                    entTo[i]    <= 1'b0;
                end
            end
        end
    end

    // Registered error pulses plus prioritised identification of the reported error.
    always_ff @(posedge SCLK) begin
        if (SRESET) begin
            err_overflow  <= 1'b0;
            err_dup_retry <= 1'b0;
            err_no_credit <= 1'b0;
            err_timeout   <= 1'b0;
            err_eos       <= 1'b0;
            err_rn_id     <= '0;
            err_txnid     <= '0;
        end else begin
            err_overflow  <= retryOvf || grantOvf;
            err_dup_retry <= retry_vld && dupHit;
            err_no_credit <= reissue_vld && !crHit;
            err_timeout   <= toHit;
            err_eos       <= eos && liveHit;
            if (retryOvf) begin
                err_rn_id <= retry_rn_id;   err_txnid <= retry_txnid;
            end else if (grantOvf) begin
                err_rn_id <= grant_rn_id;   err_txnid <= '0;
            end else if (retry_vld && dupHit) begin
                err_rn_id <= retry_rn_id;   err_txnid <= retry_txnid;
            end else if (reissue_vld && !crHit) begin
                err_rn_id <= reissue_rn_id; err_txnid <= '0;
            end else if (toHit) begin
                err_rn_id <= entRn[toIdx];  err_txnid <= entTxn[toIdx];
            end else if (eos && liveHit) begin
                err_rn_id <= entRn[liveIdx]; err_txnid <= entTxn[liveIdx];
            end
        end
    end

endmodule

// File: tb/tb_chi5pc_pcrd_retry_tracker.sv
// tb_chi5pc_pcrd_retry_tracker
// Directed vectors with hand-computed expectations for the PCrd retry tracker.
module tb_chi5pc_pcrd_retry_tracker;

    localparam int DEPTH = 4;
    localparam int TIMEOUT = 8;

    logic       SCLK = 1'b0;
    logic       SRESET;
    logic       retry_vld, grant_vld, reissue_vld, eos;
    logic [6:0] retry_rn_id, grant_rn_id, reissue_rn_id;
    logic [7:0] retry_txnid;
    logic [3:0] retry_pcrdtype, grant_pcrdtype, reissue_pcrdtype;
    logic [2:0] live_cnt;
    logic       err_overflow, err_dup_retry, err_no_credit, err_timeout, err_eos;
    logic [6:0] err_rn_id;
    logic [7:0] err_txnid;

    int errCnt = 0;
    int chkCnt = 0;

    chi5pc_pcrd_retry_tracker #(
        .DEPTH(DEPTH), .ID_WIDTH(7), .TXNID_WIDTH(8), .PCRD_WIDTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .SCLK(SCLK), .SRESET(SRESET),
        .retry_vld(retry_vld), .retry_rn_id(retry_rn_id), .retry_txnid(retry_txnid),
        .retry_pcrdtype(retry_pcrdtype),
        .grant_vld(grant_vld), .grant_rn_id(grant_rn_id), .grant_pcrdtype(grant_pcrdtype),
        .reissue_vld(reissue_vld), .reissue_rn_id(reissue_rn_id),
        .reissue_pcrdtype(reissue_pcrdtype),
        .eos(eos), .live_cnt(live_cnt),
        .err_overflow(err_overflow), .err_dup_retry(err_dup_retry),
        .err_no_credit(err_no_credit), .err_timeout(err_timeout), .err_eos(err_eos),
        .err_rn_id(err_rn_id), .err_txnid(err_txnid)
    );

    always #5 SCLK = ~SCLK;

    // Error pulses packed {overflow, dup_retry, no_credit, timeout, eos}.
    function automatic logic [4:0] errs();
        return {err_overflow, err_dup_retry, err_no_credit, err_timeout, err_eos};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        retry_vld = 0; grant_vld = 0; reissue_vld = 0; eos = 0;
        retry_rn_id = 0; retry_txnid = 0; retry_pcrdtype = 0;
        grant_rn_id = 0; grant_pcrdtype = 0; reissue_rn_id = 0; reissue_pcrdtype = 0;
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge SCLK);
        #1;
        idle();
    endtask

    task automatic retry(input int rn, input int tx, input int t);
        retry_vld = 1; retry_rn_id = 7'(rn); retry_txnid = 8'(tx); retry_pcrdtype = 4'(t);
    endtask

    task automatic grant(input int rn, input int t);
        grant_vld = 1; grant_rn_id = 7'(rn); grant_pcrdtype = 4'(t);
    endtask

    task automatic reissue(input int rn, input int t);
        reissue_vld = 1; reissue_rn_id = 7'(rn); reissue_pcrdtype = 4'(t);
    endtask

    initial begin
        idle();
        SRESET = 1;
        tick(); tick();
        SRESET = 0;
        check("reset live_cnt", 32'(live_cnt), 0);
        check("reset errs", 32'(errs()), 0);
        check("reset err_rn_id", 32'(err_rn_id), 0);
        check("reset err_txnid", 32'(err_txnid), 0);
        eos = 1; tick();
        check("eos empty", 32'(errs()), 0);

        // 1: retry, later grant, later reissue
        retry(5, 3, 1); tick();
        check("t1 live after retry", 32'(live_cnt), 1);
        tick();
        grant(5, 1); tick();
        check("t1 live after grant", 32'(live_cnt), 1);
        check("t1 errs after grant", 32'(errs()), 0);
        tick();
        reissue(5, 1); tick();
        check("t1 live after reissue", 32'(live_cnt), 0);
        check("t1 errs after reissue", 32'(errs()), 0);

        // 2: early grant, then retry, then reissue
        grant(2, 0); tick();
        check("t2 live after grant", 32'(live_cnt), 1);
        tick();
        retry(2, 9, 0); tick();
        check("t2 live after retry", 32'(live_cnt), 1);
        check("t2 errs after retry", 32'(errs()), 0);
        reissue(2, 0); tick();
        check("t2 live after reissue", 32'(live_cnt), 0);
        check("t2 errs after reissue", 32'(errs()), 0);

        // 3: reissue with nothing credited
        reissue(7, 2); tick();
        check("t3 errs", 32'(errs()), 32'b00100);
        check("t3 err_rn_id", 32'(err_rn_id), 7);
        check("t3 err_txnid", 32'(err_txnid), 0);
        tick();
        check("t3 pulse ends", 32'(errs()), 0);
        check("t3 rn_id held", 32'(err_rn_id), 7);

        // 4: retry and grant same cycle, reissue next cycle
        retry(1, 4, 3); grant(1, 3); tick();
        check("t4 live", 32'(live_cnt), 1);
        check("t4 errs", 32'(errs()), 0);
        reissue(1, 3); tick();
        check("t4 live after reissue", 32'(live_cnt), 0);
        check("t4 errs after reissue", 32'(errs()), 0);

        // Same-cycle grant does not satisfy a reissue
        retry(3, 1, 2); tick();
        grant(3, 2); reissue(3, 2); tick();
        check("samecyc errs", 32'(errs()), 32'b00100);
        check("samecyc rn_id", 32'(err_rn_id), 3);
        check("samecyc live", 32'(live_cnt), 1);
        reissue(3, 2); tick();
        check("samecyc drain", 32'(live_cnt), 0);
        check("samecyc drain errs", 32'(errs()), 0);

        // Duplicate RetryAck on a RETRIED rn/txnid; both tracked
        retry(4, 6, 0); tick();
        retry(4, 6, 0); tick();
        check("dup errs", 32'(errs()), 32'b01000);
        check("dup rn_id", 32'(err_rn_id), 4);
        check("dup txnid", 32'(err_txnid), 6);
        check("dup live", 32'(live_cnt), 2);
        grant(4, 0); tick();
        grant(4, 0); tick();
        reissue(4, 0); tick();
        reissue(4, 0); tick();
        check("dup drain live", 32'(live_cnt), 0);
        check("dup drain errs", 32'(errs()), 0);

        // 5: fill the table; dual allocation, grant overflow, retry overflow
        retry(6, 0, 1); grant(9, 1); tick();
        check("t5 dual alloc", 32'(live_cnt), 2);
        retry(6, 1, 1); tick();
        check("t5 live 3", 32'(live_cnt), 3);
        retry(6, 2, 1); grant(10, 2); tick();
        check("t5 grant ovf errs", 32'(errs()), 32'b10000);
        check("t5 grant ovf rn", 32'(err_rn_id), 10);
        check("t5 grant ovf tx", 32'(err_txnid), 0);
        check("t5 live full", 32'(live_cnt), DEPTH);
        retry(6, 3, 1); tick();
        check("t5 retry ovf errs", 32'(errs()), 32'b10000);
        check("t5 retry ovf rn", 32'(err_rn_id), 6);
        check("t5 retry ovf tx", 32'(err_txnid), 3);
        check("t5 live stays", 32'(live_cnt), DEPTH);
        SRESET = 1; retry(11, 1, 0); tick();
        SRESET = 0;
        check("t5 reset live", 32'(live_cnt), 0);
        check("t5 reset errs", 32'(errs()), 0);

        // 6: timeout, then eos, then reset
        retry(8, 5, 0); tick();
        check("t6 live", 32'(live_cnt), 1);
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check("t6 no early timeout", 32'(errs()), 0);
        end
        tick();
        check("t6 timeout", 32'(errs()), 32'b00010);
        check("t6 timeout rn", 32'(err_rn_id), 8);
        check("t6 timeout tx", 32'(err_txnid), 5);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6 timeout once", 32'(errs()), 0);
        end
        eos = 1; tick();
        check("t6 eos", 32'(errs()), 32'b00001);
        check("t6 eos rn", 32'(err_rn_id), 8);
        tick();
        check("t6 eos pulse", 32'(errs()), 0);
        SRESET = 1; tick();
        SRESET = 0;
        check("t6 reset live", 32'(live_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
